// File: rtl/vt52_pkg.sv
// Shared constants and types for the VT52-style cursor command decoder:
// control bytes, decoder states and the default 80x24 screen geometry.
package vt52_pkg;

    localparam logic [7:0] BYTE_BS  = 8'h08;
    localparam logic [7:0] BYTE_HT  = 8'h09;
    localparam logic [7:0] BYTE_LF  = 8'h0A;
    localparam logic [7:0] BYTE_CR  = 8'h0D;
    localparam logic [7:0] BYTE_ESC = 8'h1B;

    // Printable range; cursor-address bytes are also biased by the space code.
    localparam logic [7:0] BYTE_SPACE = 8'h20;
    localparam logic [7:0] BYTE_TILDE = 8'h7E;

    localparam int DEF_COL_BITS = 7;
    localparam int DEF_ROW_BITS = 5;
    localparam int DEF_LAST_COL = 79;
    localparam int DEF_LAST_ROW = 23;

    typedef enum logic [1:0] {
        IDLE,
        ESC,
        ROW,
        COL
    } state_e;

endpackage

// File: rtl/cursor_command.sv
// Decodes a host byte stream into registered cursor-position writes, character
// stores and video-buffer strobes; one byte is accepted every other cycle.
module cursor_command
    import vt52_pkg::*;
#(
    parameter int COL_BITS = DEF_COL_BITS,
    parameter int ROW_BITS = DEF_ROW_BITS,
    parameter int LAST_COL = DEF_LAST_COL,
    parameter int LAST_ROW = DEF_LAST_ROW
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic [7:0]          data,
    input  logic                valid,
    output logic                ready,
    input  logic [COL_BITS-1:0] cur_x,
    input  logic [ROW_BITS-1:0] cur_y,
    output logic [COL_BITS-1:0] new_x,
    output logic [ROW_BITS-1:0] new_y,
    output logic                x_wen,
    output logic                y_wen,
    output logic                char_wen,
    output logic [7:0]          char_out,
    output logic                scroll_up,
    output logic                clr_eol,
    output logic                clr_eos
);

    // Coordinates are widened by one bit so +1 / tab never wraps before saturation.
    localparam logic [COL_BITS:0] LAST_X = (COL_BITS+1)'(LAST_COL);
    localparam logic [ROW_BITS:0] LAST_Y = (ROW_BITS+1)'(LAST_ROW);
    localparam logic [COL_BITS:0] ONE_X  = (COL_BITS+1)'(1);
    localparam logic [ROW_BITS:0] ONE_Y  = (ROW_BITS+1)'(1);
    localparam logic [COL_BITS:0] TAB_M  = (COL_BITS+1)'(7);

    state_e                state_q, state_d;
    logic [7:0]            row_q, row_d;
    logic                  row_bad_q, row_bad_d;
    logic                  busy_q, busy_d;
    logic [COL_BITS-1:0]   new_x_q, new_x_d;
    logic [ROW_BITS-1:0]   new_y_q, new_y_d;
    logic [7:0]            char_q, char_d;
    logic                  x_wen_q, x_wen_d, y_wen_q, y_wen_d, char_wen_q, char_wen_d;
    logic                  scroll_q, scroll_d, eol_q, eol_d, eos_q, eos_d;

    logic [COL_BITS:0]     x_w, x_tab;
    logic [ROW_BITS:0]     y_w;
    logic [7:0]            off;
    logic                  accept;

    assign x_w    = {1'b0, cur_x};
    assign y_w    = {1'b0, cur_y};
    assign x_tab  = (x_w | TAB_M) + ONE_X;
    assign off    = data - BYTE_SPACE;
    assign accept = valid && !busy_q;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        row_bad_d  = row_bad_q;
        busy_d     = 1'b0;
        new_x_d    = new_x_q;
        new_y_d    = new_y_q;
        char_d     = char_q;
        x_wen_d    = 1'b0;
        y_wen_d    = 1'b0;
        char_wen_d = 1'b0;
        scroll_d   = 1'b0;
        eol_d      = 1'b0;
        eos_d      = 1'b0;

        if (accept) begin
            busy_d = 1'b1;
            case (state_q)
                IDLE: begin
                    if (data >= BYTE_SPACE && data <= BYTE_TILDE) begin
                        char_wen_d = 1'b1;
                        char_d     = data;
                        if (x_w < LAST_X) begin
                            x_wen_d = 1'b1;
                            new_x_d = COL_BITS'(x_w + ONE_X);
                        end
                    end else begin
                        case (data)
                            BYTE_CR: begin
                                x_wen_d = 1'b1;
                                new_x_d = '0;
                            end
                            BYTE_LF: begin
                                if (y_w < LAST_Y) begin
                                    y_wen_d = 1'b1;
                                    new_y_d = ROW_BITS'(y_w + ONE_Y);
                                end else begin
                                    scroll_d = 1'b1;
                                end
                            end
                            BYTE_BS: begin
                                if (cur_x != '0) begin
                                    x_wen_d = 1'b1;
                                    new_x_d = COL_BITS'(x_w - ONE_X);
                                end
                            end
                            BYTE_HT: begin
                                if (x_w < LAST_X) begin
                                    x_wen_d = 1'b1;
                                    new_x_d = (x_tab > LAST_X) ? COL_BITS'(LAST_X)
                                                               : COL_BITS'(x_tab);
                                end
                            end
                            BYTE_ESC: state_d = ESC;
                            default:  ;
                        endcase
                    end
                end

                ESC: begin
                    state_d = IDLE;
                    case (data)
                        8'h41: if (cur_y != '0) begin
                            y_wen_d = 1'b1;
                            new_y_d = ROW_BITS'(y_w - ONE_Y);
                        end
                        8'h42: if (y_w < LAST_Y) begin
                            y_wen_d = 1'b1;
                            new_y_d = ROW_BITS'(y_w + ONE_Y);
                        end
                        8'h43: if (x_w < LAST_X) begin
                            x_wen_d = 1'b1;
                            new_x_d = COL_BITS'(x_w + ONE_X);
                        end
                        8'h44: if (cur_x != '0) begin
                            x_wen_d = 1'b1;
                            new_x_d = COL_BITS'(x_w - ONE_X);
                        end
                        8'h48: begin
                            x_wen_d = 1'b1;
                            y_wen_d = 1'b1;
                            new_x_d = '0;
                            new_y_d = '0;
                        end
                        8'h4A:    eos_d   = 1'b1;
                        8'h4B:    eol_d   = 1'b1;
                        8'h59:    state_d = ROW;
                        BYTE_ESC: state_d = ESC;
                        default:  ;
                    endcase
                end

                ROW: begin
                    row_d     = off;
                    row_bad_d = (data < BYTE_SPACE);
                    state_d   = COL;
                end

                COL: begin
                    // Out-of-range coordinates are dropped per axis rather than clipped.
                    if (!row_bad_q && int'(row_q) <= LAST_ROW) begin
                        y_wen_d = 1'b1;
                        new_y_d = ROW_BITS'(row_q);
                    end
                    if (data >= BYTE_SPACE && int'(off) <= LAST_COL) begin
                        x_wen_d = 1'b1;
                        new_x_d = COL_BITS'(off);
                    end
                    state_d = IDLE;
                end

                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q    <= IDLE;
            row_q      <= '0;
            row_bad_q  <= 1'b0;
            busy_q     <= 1'b0;
            new_x_q    <= '0;
            new_y_q    <= '0;
            char_q     <= '0;
            x_wen_q    <= 1'b0;
            y_wen_q    <= 1'b0;
            char_wen_q <= 1'b0;
            scroll_q   <= 1'b0;
            eol_q      <= 1'b0;
            eos_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            row_bad_q  <= row_bad_d;
            busy_q     <= busy_d;
            new_x_q    <= new_x_d;
            new_y_q    <= new_y_d;
            char_q     <= char_d;
            x_wen_q    <= x_wen_d;
            y_wen_q    <= y_wen_d;
            char_wen_q <= char_wen_d;
            scroll_q   <= scroll_d;
            eol_q      <= eol_d;
            eos_q      <= eos_d;
        end
    end

    assign ready     = !busy_q;
    assign new_x     = new_x_q;
    assign new_y     = new_y_q;
    assign x_wen     = x_wen_q;
    assign y_wen     = y_wen_q;
    assign char_wen  = char_wen_q;
    assign char_out  = char_q;
    assign scroll_up = scroll_q;
    assign clr_eol   = eol_q;
    assign clr_eos   = eos_q;

endmodule

// File: tb/tb_cursor_command.sv
// Directed bench for cursor_command: each task drives one scenario and checks
// the registered outputs one cycle after the byte is accepted.
module tb_cursor_command;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic [7:0] data = 8'h00;
    logic       valid = 1'b0;
    logic       ready;
    logic [6:0] cur_x = '0;
    logic [4:0] cur_y = '0;
    logic [6:0] new_x;
    logic [4:0] new_y;
    logic       x_wen, y_wen, char_wen, scroll_up, clr_eol, clr_eos;
    logic [7:0] char_out;

    int passed = 0;
    int total  = 0;

    cursor_command dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .data     (data),
        .valid    (valid),
        .ready    (ready),
        .cur_x    (cur_x),
        .cur_y    (cur_y),
        .new_x    (new_x),
        .new_y    (new_y),
        .x_wen    (x_wen),
        .y_wen    (y_wen),
        .char_wen (char_wen),
        .char_out (char_out),
        .scroll_up(scroll_up),
        .clr_eol  (clr_eol),
        .clr_eos  (clr_eos)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Present a byte, wait (bounded) for ready, and return #1 after the accepting edge.
    task automatic send(input logic [7:0] b);
        int waited = 0;
        @(negedge clk);
        data  = b;
        valid = 1'b1;
        while (!ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (!ready) begin
            total++;
            $display("FAIL send_timeout: ready=%b required 1 for byte %h", ready, b);
        end
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        cur_x = 7'd5;
        cur_y = 5'd3;
        @(negedge clk);
        data  = 8'h41;
        valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (char_wen !== 1'b0) $display("FAIL rst_char_wen: got %b required 0", char_wen); else passed++;
        total++; if (x_wen !== 1'b0) $display("FAIL rst_x_wen: got %b required 0", x_wen); else passed++;
        total++; if ({new_x, new_y} !== 12'h000) $display("FAIL rst_new_xy: got %h required 000", {new_x, new_y}); else passed++;
        total++; if (char_out !== 8'h00) $display("FAIL rst_char_out: got %h required 00", char_out); else passed++;
        total++; if ({y_wen, scroll_up, clr_eol, clr_eos} !== 4'b0000) $display("FAIL rst_strobes: got %b required 0000", {y_wen, scroll_up, clr_eol, clr_eos}); else passed++;
        @(negedge clk);
        valid = 1'b0;
        clr_n = 1'b1;
        @(posedge clk);
        #1;
        total++; if (ready !== 1'b1) $display("FAIL rst_ready: got %b required 1", ready); else passed++;
    endtask

    task automatic test_printable();
        cur_x = 7'd5;
        cur_y = 5'd3;
        send(8'h41);
        total++; if (char_wen !== 1'b1) $display("FAIL pr_char_wen: got %b required 1", char_wen); else passed++;
        total++; if (char_out !== 8'h41) $display("FAIL pr_char_out: got %h required 41", char_out); else passed++;
        total++; if (x_wen !== 1'b1 || new_x !== 7'd6) $display("FAIL pr_x: wen=%b x=%0d required wen=1 x=6", x_wen, new_x); else passed++;
        total++; if (y_wen !== 1'b0) $display("FAIL pr_y_wen: got %b required 0", y_wen); else passed++;
        total++; if (ready !== 1'b0) $display("FAIL pr_ready_n1: got %b required 0", ready); else passed++;
        @(posedge clk);
        #1;
        total++; if (ready !== 1'b1) $display("FAIL pr_ready_n2: got %b required 1", ready); else passed++;
        total++; if (char_wen !== 1'b0 || x_wen !== 1'b0) $display("FAIL pr_strobe_len: char_wen=%b x_wen=%b required 0 0", char_wen, x_wen); else passed++;
        cur_x = 7'd79;
        send(8'h7E);
        total++; if (char_wen !== 1'b1 || x_wen !== 1'b0) $display("FAIL pr_last_col: char_wen=%b x_wen=%b required 1 0", char_wen, x_wen); else passed++;
        send(8'h7F);
        total++; if (char_wen !== 1'b0) $display("FAIL pr_del_ignored: got %b required 0", char_wen); else passed++;
    endtask

    task automatic test_cursor_address();
        cur_x = 7'd40;
        cur_y = 5'd12;
        send(8'h1B);
        send(8'h59);
        send(8'h2A);
        total++; if ({x_wen, y_wen} !== 2'b00) $display("FAIL ca_row_quiet: wens=%b required 00", {x_wen, y_wen}); else passed++;
        send(8'h35);
        total++; if (y_wen !== 1'b1 || new_y !== 5'd10) $display("FAIL ca_row: wen=%b y=%0d required wen=1 y=10", y_wen, new_y); else passed++;
        total++; if (x_wen !== 1'b1 || new_x !== 7'd21) $display("FAIL ca_col: wen=%b x=%0d required wen=1 x=21", x_wen, new_x); else passed++;
        send(8'h1B);
        send(8'h59);
        send(8'h40);
        send(8'h35);
        total++; if ({x_wen, y_wen} !== 2'b10 || new_x !== 7'd21) $display("FAIL ca_bad_row: wens=%b x=%0d required 10 x=21", {x_wen, y_wen}, new_x); else passed++;
    endtask

    task automatic test_limits();
        cur_x = 7'd50;
        cur_y = 5'd23;
        send(8'h0A);
        total++; if (scroll_up !== 1'b1 || y_wen !== 1'b0) $display("FAIL lf_bottom: scroll=%b y_wen=%b required 1 0", scroll_up, y_wen); else passed++;
        cur_y = 5'd7;
        send(8'h0A);
        total++; if (y_wen !== 1'b1 || new_y !== 5'd8 || scroll_up !== 1'b0) $display("FAIL lf_mid: wen=%b y=%0d scroll=%b required 1 8 0", y_wen, new_y, scroll_up); else passed++;
        send(8'h0D);
        total++; if (x_wen !== 1'b1 || new_x !== 7'd0) $display("FAIL cr: wen=%b x=%0d required 1 0", x_wen, new_x); else passed++;
        cur_x = 7'd0;
        send(8'h08);
        total++; if ({x_wen, y_wen, char_wen, scroll_up} !== 4'b0000) $display("FAIL bs_left: strobes=%b required 0000", {x_wen, y_wen, char_wen, scroll_up}); else passed++;
        cur_x = 7'd9;
        send(8'h08);
        total++; if (x_wen !== 1'b1 || new_x !== 7'd8) $display("FAIL bs_mid: wen=%b x=%0d required 1 8", x_wen, new_x); else passed++;
    endtask

    task automatic test_tab();
        cur_x = 7'd3;
        send(8'h09);
        total++; if (x_wen !== 1'b1 || new_x !== 7'd8) $display("FAIL ht_3: wen=%b x=%0d required 1 8", x_wen, new_x); else passed++;
        cur_x = 7'd77;
        send(8'h09);
        total++; if (x_wen !== 1'b1 || new_x !== 7'd79) $display("FAIL ht_77: wen=%b x=%0d required 1 79", x_wen, new_x); else passed++;
        cur_x = 7'd79;
        send(8'h09);
        total++; if (x_wen !== 1'b0) $display("FAIL ht_79: wen=%b required 0", x_wen); else passed++;
    endtask

    task automatic test_reset_mid_sequence();
        cur_x = 7'd10;
        cur_y = 5'd4;
        send(8'h1B);
        send(8'h59);
        send(8'h25);
        @(negedge clk);
        clr_n = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        send(8'h30);
        total++; if (char_wen !== 1'b1 || char_out !== 8'h30) $display("FAIL rm_printable: wen=%b char=%h required 1 30", char_wen, char_out); else passed++;
        total++; if (x_wen !== 1'b1 || new_x !== 7'd11 || y_wen !== 1'b0) $display("FAIL rm_xy: x_wen=%b x=%0d y_wen=%b required 1 11 0", x_wen, new_x, y_wen); else passed++;
    endtask

    task automatic test_escape();
        cur_x = 7'd40;
        cur_y = 5'd12;
        send(8'h1B);
        send(8'h1B);
        send(8'h48);
        total++; if ({x_wen, y_wen} !== 2'b11 || {new_x, new_y} !== 12'h000) $display("FAIL esc_home: wens=%b xy=%h required 11 000", {x_wen, y_wen}, {new_x, new_y}); else passed++;
        send(8'h1B);
        send(8'h5A);
        total++; if ({x_wen, y_wen, char_wen, scroll_up, clr_eol, clr_eos} !== 6'b0) $display("FAIL esc_z: strobes=%b required 000000", {x_wen, y_wen, char_wen, scroll_up, clr_eol, clr_eos}); else passed++;
        send(8'h42);
        total++; if (char_wen !== 1'b1 || y_wen !== 1'b0) $display("FAIL esc_z_idle: char_wen=%b y_wen=%b required 1 0", char_wen, y_wen); else passed++;
        send(8'h1B);
        send(8'h4A);
        total++; if (clr_eos !== 1'b1 || clr_eol !== 1'b0) $display("FAIL esc_j: eos=%b eol=%b required 1 0", clr_eos, clr_eol); else passed++;
        send(8'h1B);
        send(8'h4B);
        total++; if (clr_eol !== 1'b1 || clr_eos !== 1'b0) $display("FAIL esc_k: eol=%b eos=%b required 1 0", clr_eol, clr_eos); else passed++;
        send(8'h1B);
        send(8'h42);
        total++; if (y_wen !== 1'b1 || new_y !== 5'd13) $display("FAIL esc_down: wen=%b y=%0d required 1 13", y_wen, new_y); else passed++;
        cur_y = 5'd0;
        send(8'h1B);
        send(8'h41);
        total++; if (y_wen !== 1'b0) $display("FAIL esc_up_top: wen=%b required 0", y_wen); else passed++;
        cur_x = 7'd79;
        send(8'h1B);
        send(8'h43);
        total++; if (x_wen !== 1'b0) $display("FAIL esc_right_edge: wen=%b required 0", x_wen); else passed++;
        send(8'h1B);
        send(8'h44);
        total++; if (x_wen !== 1'b1 || new_x !== 7'd78) $display("FAIL esc_left: wen=%b x=%0d required 1 78", x_wen, new_x); else passed++;
    endtask

    initial begin
        test_reset();
        test_printable();
        test_cursor_address();
        test_limits();
        test_tab();
        test_reset_mid_sequence();
        test_escape();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
